// File: rtl/array_reduce_seq.sv
// -----------------------------------------------------------------------------
// array_reduce_seq
//
// Multi-cycle reduction of two packed N-element unsigned arrays into one
// result. It has two modes:
//   mode = 0 : element-sum, sum of (a[i] + b[i])
//   mode = 1 : dot product, sum of (a[i] * b[i])
// Each clock in RUN reduces LANES elements in ascending index order. One
// operation takes C = N/LANES RUN cycles. The operands and the mode are
// snapshotted on the accepted start. If the result does not fit in SW bits,
// it saturates to all-ones and ovf is set.
//
// Ports
//   clk    in   1     clock, rising edge
//   res    in   1     synchronous reset, active-low
//   start  in   1     request; sampled only in IDLE
//   mode   in   1     0 = element-sum, 1 = dot product; latched with start
//   num1   in   N*W   array A, element i = num1[i*W +: W]
//   num2   in   N*W   array B, same packing
//   busy   out  1     operation in progress
//   done   out  1     one-cycle pulse when sum/ovf have just been updated
//   sum    out  SW    last result; held until the next completion or reset
//   ovf    out  1     last result saturated; updated together with sum
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; sum/ovf hold the previous result
// RUN   | accumulating LANES terms per clock; the last element group
//       | publishes sum/ovf, pulses done and returns to IDLE
// -----------------------------------------------------------------------------
module array_reduce_seq #(
    parameter int N     = 10,
    parameter int W     = 8,
    parameter int SW    = 20,
    parameter int LANES = 1
) (
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic            mode,
    input  logic [N*W-1:0]  num1,
    input  logic [N*W-1:0]  num2,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   sum,
    output logic            ovf
);

    // A product term (2W bits) is the widest term. A sum term needs only W+1 bits.
    localparam int TW = 2 * W;
    // The working width holds the saturated accumulator plus any single term
    // without wrapping, so every overflow is caught.
    localparam int AW = ((SW > TW) ? SW : TW) + 1;
    localparam int IW = $clog2(N + 1);

    localparam logic [AW-1:0] SAT      = {{(AW-SW){1'b0}}, {SW{1'b1}}};
    localparam logic [IW-1:0] STEP     = IW'(LANES);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - LANES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [N*W-1:0]  a_q;
    logic [N*W-1:0]  b_q;
    logic            mode_q;
    logic [SW-1:0]   acc_q;
    logic            ovf_int_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            done_q;
    logic [SW-1:0]   sum_q;
    logic            ovf_q;

    logic [N*W-1:0]  a_win;
    logic [N*W-1:0]  b_win;
    logic [W-1:0]    elem_a;
    logic [W-1:0]    elem_b;
    logic [TW-1:0]   term;
    logic [AW-1:0]   acc_d;
    logic            ovf_int_d;

    // Shift the current element group down to bit 0. The lanes can then use
    // fixed slices.
    assign a_win = a_q >> (W * int'(idx_q));
    assign b_win = b_q >> (W * int'(idx_q));

    // Fold the LANES terms in one at a time. The clamp is applied after each
    // term, so a saturated accumulator stays pinned at all-ones.
    always_comb begin
        acc_d     = AW'(acc_q);
        ovf_int_d = ovf_int_q;
        elem_a    = '0;
        elem_b    = '0;
        term      = '0;
        for (int l = 0; l < LANES; l++) begin
            elem_a = a_win[l*W +: W];
            elem_b = b_win[l*W +: W];
            term   = mode_q ? (TW'(elem_a) * TW'(elem_b))
                            : (TW'(elem_a) + TW'(elem_b));
            acc_d  = acc_d + AW'(term);
            if (acc_d > SAT) begin
                acc_d     = SAT;
                ovf_int_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            acc_q     <= '0;
            ovf_int_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q       <= num1;
                        b_q       <= num2;
                        mode_q    <= mode;
                        acc_q     <= '0;
                        ovf_int_q <= 1'b0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d[SW-1:0];
                    ovf_int_q <= ovf_int_d;
                    idx_q     <= idx_q + STEP;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= acc_d[SW-1:0];
                        ovf_q   <= ovf_int_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_array_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_array_reduce_seq
//
// Directed bench for array_reduce_seq. Four instances share the same
// stimulus: the default instance, one with SW=16, one with LANES=2 and one
// with LANES=5.
// -----------------------------------------------------------------------------
module tb_array_reduce_seq;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic        mode;
    logic [79:0] num1;
    logic [79:0] num2;

    logic        busy_d, done_d, ovf_d;
    logic [19:0] sum_d;
    logic        busy_s, done_s, ovf_s;
    logic [15:0] sum_s;
    logic        busy_l2, done_l2, ovf_l2;
    logic [19:0] sum_l2;
    logic        busy_l5, done_l5, ovf_l5;
    logic [19:0] sum_l5;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat  [4];
    logic [63:0] rsum [4];
    logic        rovf [4];
    logic        busy_c1, busy_c10, done_c11;

    int v1a [10] = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20};
    int v1b [10] = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19};
    int v2a [10] = '{5, 4, 3, 2, 1, 1, 2, 3, 4, 5};
    int v2b [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    logic [79:0] p1a, p1b, p2a, p2b, pff;

    always #5 clk = ~clk;

    array_reduce_seq u_def (
        .clk(clk), .res(res), .start(start), .mode(mode), .num1(num1), .num2(num2),
        .busy(busy_d), .done(done_d), .sum(sum_d), .ovf(ovf_d)
    );

    array_reduce_seq #(.SW(16)) u_s16 (
        .clk(clk), .res(res), .start(start), .mode(mode), .num1(num1), .num2(num2),
        .busy(busy_s), .done(done_s), .sum(sum_s), .ovf(ovf_s)
    );

    array_reduce_seq #(.LANES(2)) u_l2 (
        .clk(clk), .res(res), .start(start), .mode(mode), .num1(num1), .num2(num2),
        .busy(busy_l2), .done(done_l2), .sum(sum_l2), .ovf(ovf_l2)
    );

    array_reduce_seq #(.LANES(5)) u_l5 (
        .clk(clk), .res(res), .start(start), .mode(mode), .num1(num1), .num2(num2),
        .busy(busy_l5), .done(done_l5), .sum(sum_l5), .ovf(ovf_l5)
    );

    // Packs a list that is written MSB element first.
    function automatic logic [79:0] pack(input int v [10]);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'(v[9-i]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one start. Then it watches 14 edges and records, per instance,
    // the edge on which done appeared and the result at that edge. When
    // scramble is set, num1 and mode are disturbed right after the start edge.
    task automatic run_op(input logic m, input logic [79:0] n1, input logic [79:0] n2,
                          input bit scramble);
        for (int i = 0; i < 4; i++) begin
            lat[i]  = -1;
            rsum[i] = '1;
            rovf[i] = 1'bx;
        end
        busy_c1 = 1'b0; busy_c10 = 1'b1; done_c11 = 1'b1;
        @(negedge clk);
        num1 = n1; num2 = n2; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            num1 = 80'h0;
            mode = ~m;
        end
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 1)  busy_c1  = busy_d;
            if (c == 10) busy_c10 = busy_d;
            if (c == 11) done_c11 = done_d;
            if (done_d  && lat[0] < 0) begin lat[0] = c; rsum[0] = 64'(sum_d);  rovf[0] = ovf_d;  end
            if (done_s  && lat[1] < 0) begin lat[1] = c; rsum[1] = 64'(sum_s);  rovf[1] = ovf_s;  end
            if (done_l2 && lat[2] < 0) begin lat[2] = c; rsum[2] = 64'(sum_l2); rovf[2] = ovf_l2; end
            if (done_l5 && lat[3] < 0) begin lat[3] = c; rsum[3] = 64'(sum_l5); rovf[3] = ovf_l5; end
        end
        if (scramble) mode = m;
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_sum, input logic e_ovf,
                             input logic [63:0] e_s16, input logic e_ovf16);
        check({tag, "_lat_def"}, 64'(lat[0]), 10);
        check({tag, "_lat_s16"}, 64'(lat[1]), 10);
        check({tag, "_lat_l2"},  64'(lat[2]), 5);
        check({tag, "_lat_l5"},  64'(lat[3]), 2);
        check({tag, "_sum_def"}, rsum[0], e_sum);
        check({tag, "_ovf_def"}, 64'(rovf[0]), 64'(e_ovf));
        check({tag, "_sum_s16"}, rsum[1], e_s16);
        check({tag, "_ovf_s16"}, 64'(rovf[1]), 64'(e_ovf16));
        check({tag, "_sum_l2"},  rsum[2], e_sum);
        check({tag, "_sum_l5"},  rsum[3], e_sum);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        p1a = pack(v1a); p1b = pack(v1b);
        p2a = pack(v2a); p2b = pack(v2b);
        pff = {80{1'b1}};

        res = 1'b0; start = 1'b0; mode = 1'b0; num1 = '0; num2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_d), 0);
        check("rst_done", 64'(done_d), 0);
        check("rst_sum",  64'(sum_d),  0);
        check("rst_ovf",  64'(ovf_d),  0);
        @(negedge clk);
        res = 1'b1;

        // Vector 1: element-sum, then dot product.
        run_op(1'b0, p1a, p1b, 1'b0);
        check_all("v1m0", 210, 1'b0, 210, 1'b0);
        check("v1m0_busy_c1",  64'(busy_c1),  1);
        check("v1m0_busy_done", 64'(busy_c10), 0);
        check("v1m0_done_pulse", 64'(done_c11), 0);
        check("v1m0_sum_hold", 64'(sum_d), 210);
        run_op(1'b1, p1a, p1b, 1'b0);
        check_all("v1m1", 1430, 1'b0, 1430, 1'b0);

        // Vector 2. The snapshot must ignore input changes after the start edge.
        run_op(1'b0, p2a, p2b, 1'b0);
        check_all("v2m0", 85, 1'b0, 85, 1'b0);
        run_op(1'b0, p2a, p2b, 1'b1);
        check_all("v2m0_scr", 85, 1'b0, 85, 1'b0);
        run_op(1'b1, p2a, p2b, 1'b0);
        check_all("v2m1", 165, 1'b0, 165, 1'b0);

        // All 0xFF: overflow boundary for SW=16.
        run_op(1'b1, pff, pff, 1'b0);
        check_all("ffm1", 650250, 1'b0, 65535, 1'b1);
        run_op(1'b0, pff, pff, 1'b0);
        check_all("ffm0", 5100, 1'b0, 5100, 1'b0);

        // Start held high for 30 cycles: an operation completes every 11 cycles.
        @(negedge clk);
        num1 = p1a; num2 = p1b; mode = 1'b1; start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_done_c%0d", c), 64'(done_d), 64'((c % 11) == 0));
            check($sformatf("b2b_busy_c%0d", c), 64'(busy_d), 64'((c % 11) != 0));
            if (done_d) begin
                ndone++;
                check("b2b_sum", 64'(sum_d), 1430);
            end
        end
        check("b2b_ndone", 64'(ndone), 2);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);

        // Reset in RUN cycle 4 aborts the operation without a done pulse.
        run_op(1'b0, pff, pff, 1'b0);
        @(negedge clk);
        num1 = p1a; num2 = p1b; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy_d), 0);
        check("abort_done", 64'(done_d), 0);
        check("abort_sum",  64'(sum_d),  0);
        check("abort_ovf",  64'(ovf_d),  0);
        check("abort_sum_s16", 64'(sum_s), 0);
        @(negedge clk);
        res = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done_d) ndone++;
        end
        check("abort_nodone", 64'(ndone), 0);
        run_op(1'b1, p2a, p2b, 1'b0);
        check_all("after_abort", 165, 1'b0, 165, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
